// File: rtl/rr_arbiter_4x_nbit_if.sv
// rtl/rr_arbiter_4x_nbit_if.sv - handshake bundle between four producers, the arbiter and one consumer
//
// Purpose: groups the request side (valid/ready/last plus the four data
// words a..d) and the single output channel (valid/ready/data/sel) together
// with the busy flag, so the arbiter and its environment share one port.
//
// Ports (signals):
//   req_valid[3:0]   producer -> arbiter   word pending per requester (0=a..3=d)
//   req_ready[3:0]   arbiter  -> producer  one-hot accept strobe, or 0
//   req_last[3:0]    producer -> arbiter   current word closes the packet
//   a, b, c, d       producer -> arbiter   requester data words
//   out_valid        arbiter  -> consumer  out_data/out_sel hold a word
//   out_ready        consumer -> arbiter   consumer takes the word this cycle
//   out_data         arbiter  -> consumer  registered winning word
//   out_sel[1:0]     arbiter  -> consumer  index of the supplying requester
//   busy             arbiter  -> consumer  output word held or packet lock held
//
// Modports: master = producers/consumer side, slave = arbiter side.

interface rr_arbiter_4x_nbit_if #(
  parameter int BUS_WIDTH = 8
);
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  logic [3:0]           req_last;
  logic [BUS_WIDTH-1:0] a;
  logic [BUS_WIDTH-1:0] b;
  logic [BUS_WIDTH-1:0] c;
  logic [BUS_WIDTH-1:0] d;
  logic                 out_valid;
  logic                 out_ready;
  logic [BUS_WIDTH-1:0] out_data;
  logic [1:0]           out_sel;
  logic                 busy;

  modport master (
    output req_valid, req_last, a, b, c, d, out_ready,
    input  req_ready, out_valid, out_data, out_sel, busy
  );

  modport slave (
    input  req_valid, req_last, a, b, c, d, out_ready,
    output req_ready, out_valid, out_data, out_sel, busy
  );
endinterface

// File: rtl/rr_arbiter_4x_nbit.sv
// rtl/rr_arbiter_4x_nbit.sv - round-robin 4:1 arbiter with a one-entry registered output stage
//
// Purpose: shares one BUS_WIDTH output channel between four valid/ready
// requesters. Each cycle the output stage can load (empty, or being drained),
// the first requesting index found from ptr upward (mod 4) is granted, its
// word is captured into the output register and ptr moves past the winner.
//
// Optional feature (macro ARB_LOCK_EN): packet lock. Once a requester wins,
// only it may win again until a word with its req_last bit set is accepted;
// the pointer then moves past it. Without the macro req_last is ignored and
// arbitration is per word.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (also forces req_ready to 0)
//   bus    rr_arbiter_4x_nbit_if.slave: req_valid/req_ready/req_last, a..d,
//          out_valid/out_ready/out_data/out_sel, busy

module rr_arbiter_4x_nbit #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rr_arbiter_4x_nbit_if.slave    bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t               state;
  logic [1:0]           ptr;
  logic                 lock;

  logic                 can_load;
  logic [3:0]           eligible;
  logic [7:0]           doubled;
  logic [3:0]           rotated;
  logic                 any_req;
  logic [1:0]           offset;
  logic [1:0]           grant;
  logic                 accept;
  logic [BUS_WIDTH-1:0] mux_word;

`ifdef ARB_LOCK_EN
  logic [1:0]           owner;
`else
  logic                 unused_last;

  assign lock        = 1'b0;
  assign unused_last = ^bus.req_last;
`endif

  // Grant selection: rotate the eligible vector so ptr lands on bit 0, take
  // the lowest set bit there, then rotate the index back by adding ptr.
  always_comb begin
    can_load = (state == EMPTY) || bus.out_ready;

    eligible = bus.req_valid;
`ifdef ARB_LOCK_EN
    // While a packet is in flight only its owner is a candidate; if the
    // owner has nothing pending, nobody is granted.
    if (lock) begin
      eligible = bus.req_valid & (4'b0001 << owner);
    end
`endif

    doubled = {eligible, eligible} >> ptr;
    rotated = doubled[3:0];
    any_req = |rotated;

    if (rotated[0]) begin
      offset = 2'd0;
    end else if (rotated[1]) begin
      offset = 2'd1;
    end else if (rotated[2]) begin
      offset = 2'd2;
    end else begin
      offset = 2'd3;
    end

    grant = ptr + offset;

    // rst_n gates the accept so no producer sees a ready during reset.
    accept        = can_load && any_req && rst_n;
    bus.req_ready = accept ? (4'b0001 << grant) : 4'b0000;

    case (grant)
      2'd0:    mux_word = bus.a;
      2'd1:    mux_word = bus.b;
      2'd2:    mux_word = bus.c;
      default: mux_word = bus.d;
    endcase
  end

  // Output stage: EMPTY/FULL is exactly out_valid. A capture always wins over
  // a drain, which gives one word per cycle while out_ready stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      bus.out_data <= '0;
      bus.out_sel  <= 2'd0;
      ptr          <= 2'd0;
`ifdef ARB_LOCK_EN
      lock         <= 1'b0;
      owner        <= 2'd0;
`endif
    end else begin
      if (accept) begin
        state        <= FULL;
        bus.out_data <= mux_word;
        bus.out_sel  <= grant;
`ifdef ARB_LOCK_EN
        if (bus.req_last[grant]) begin
          lock <= 1'b0;
          ptr  <= grant + 2'd1;
        end else begin
          // Pointer stays put mid-packet; the owner keeps the channel.
          lock  <= 1'b1;
          owner <= grant;
        end
`else
        ptr <= grant + 2'd1;
`endif
      end else if (bus.out_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.busy      = (state == FULL) || lock;

endmodule

// File: tb/tb_rr_arbiter_4x_nbit.sv
// tb/tb_rr_arbiter_4x_nbit.sv - self-checking bench for rr_arbiter_4x_nbit

module tb_rr_arbiter_4x_nbit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_4x_nbit_if #(.BUS_WIDTH(8)) bus ();

  rr_arbiter_4x_nbit #(.BUS_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: output register contents, pointer and packet owner.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_sel   = 0;
  int         m_ptr   = 0;
  logic       m_lock  = 1'b0;
  int         m_owner = 0;

  function automatic int model_grant();
    if (m_valid && !bus.out_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (m_lock && idx != m_owner) continue;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_word(input int idx);
    case (idx)
      0:       return bus.a;
      1:       return bus.b;
      2:       return bus.c;
      default: return bus.d;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int gi;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      m_ptr   = 0;
      m_lock  = 1'b0;
      m_owner = 0;
    end else begin
      gi = model_grant();
      if (gi >= 0) begin
        m_valid = 1'b1;
        m_data  = model_word(gi);
        m_sel   = gi;
`ifdef ARB_LOCK_EN
        if (bus.req_last[gi]) begin
          m_lock = 1'b0;
          m_ptr  = (gi + 1) % 4;
        end else begin
          m_lock  = 1'b1;
          m_owner = gi;
        end
`else
        m_ptr = (gi + 1) % 4;
`endif
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int gi;
    logic [3:0] exp_ready;
    if (!rst_n) begin
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    end else begin
      gi = model_grant();
      exp_ready = (gi < 0) ? 4'b0000 : (4'b0001 << gi);
      check("m_req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("m_busy", 32'(bus.busy), 32'(m_valid | m_lock));
      if (m_valid) begin
        check("m_out_data", 32'(bus.out_data), 32'(m_data));
        check("m_out_sel", 32'(bus.out_sel), 32'(m_sel));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         seq1_sel[5]  = '{0, 1, 2, 3, 0};
  logic [7:0] seq1_data[5] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0A};
`ifdef ARB_LOCK_EN
  int         seq5_sel[5]  = '{0, 0, 0, 1, 0};
`else
  int         seq5_sel[5]  = '{0, 1, 0, 1, 0};
`endif

  initial begin
    int zeros;
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    bus.a = 8'h00; bus.b = 8'h00; bus.c = 8'h00; bus.d = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state with requests already pending.
    repeat (2) tick();
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    bus.a = 8'h0A; bus.b = 8'h0B; bus.c = 8'h0C; bus.d = 8'h0D;
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    check("reset_out_sel", 32'(bus.out_sel), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t1_first_ready", 32'(bus.req_ready), 32'b0001);

    // All four requesting: plain rotation, one word per cycle.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_valid", 32'(bus.out_valid), 32'd1);
      check("t1_sel", 32'(bus.out_sel), 32'(seq1_sel[i]));
      check("t1_data", 32'(bus.out_data), 32'(seq1_data[i]));
    end

    // Single requester c wins every cycle.
    bus.req_valid = 4'b0100;
    bus.c = 8'h55;
    #1;
    check("t2_ready", 32'(bus.req_ready), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_ready_each", 32'(bus.req_ready), 32'b0100);
      check("t2_sel", 32'(bus.out_sel), 32'd2);
      check("t2_data", 32'(bus.out_data), 32'h55);
    end

    // ptr=3 with requesters d and a: 3 then wrap to 0, then drain.
    bus.req_valid = 4'b1001;
    #1;
    check("t4_ready_d", 32'(bus.req_ready), 32'b1000);
    tick();
    check("t4_sel_d", 32'(bus.out_sel), 32'd3);
    check("t4_data_d", 32'(bus.out_data), 32'h0D);
    check("t4_ready_a", 32'(bus.req_ready), 32'b0001);
    tick();
    check("t4_sel_a", 32'(bus.out_sel), 32'd0);
    check("t4_data_a", 32'(bus.out_data), 32'h0A);
    bus.req_valid = 4'b0000;
    #1;
    check("t4_idle_ready", 32'(bus.req_ready), 32'd0);
    check("t4_still_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("t4_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: word from a held stable for 5 cycles, then b is next.
    bus.a = 8'h11;
    bus.req_valid = 4'b0001;
    #1;
    check("t3_ready_a", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_data", 32'(bus.out_data), 32'h11);
      check("t3_hold_sel", 32'(bus.out_sel), 32'd0);
      check("t3_hold_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t3_ready_b", 32'(bus.req_ready), 32'b0010);
    tick();
    check("t3_sel_b", 32'(bus.out_sel), 32'd1);
    check("t3_data_b", 32'(bus.out_data), 32'h0B);
    bus.req_valid = 4'b0000;
    tick();
    check("t3_drained", 32'(bus.out_valid), 32'd0);

    // Packet lock (or its absence): a sends a 3-word packet, b always waiting.
    bus.a = 8'h0A;
    bus.req_valid = 4'b0011;
    zeros = 0;
    for (int i = 0; i < 5; i++) begin
      bus.req_last = {2'b00, 1'b1, (zeros == 2)};
      tick();
      check("t5_sel", 32'(bus.out_sel), 32'(seq5_sel[i]));
      if (seq5_sel[i] == 0) zeros++;
    end
    bus.req_last = 4'b0000;

    // Asynchronous reset mid-stream with a word held.
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid_in_reset", 32'(bus.out_valid), 32'd0);
    check("t6_ready_in_reset", 32'(bus.req_ready), 32'd0);
    check("t6_busy_in_reset", 32'(bus.busy), 32'd0);
    bus.req_valid = 4'b1111;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_ready_after", 32'(bus.req_ready), 32'b0001);
    tick();
    check("t6_sel_after", 32'(bus.out_sel), 32'd0);
    check("t6_data_after", 32'(bus.out_data), 32'h0A);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
